// File: rtl/serial_frame_scheduler.sv
// serial_frame_scheduler
//   Round-robin arbiter sharing one serial link between NUM_REQ byte
//   requesters. A granted byte is framed as start(0), 8 data bits LSB-first,
//   optional even-parity bit, stop(1), then GAP_CYCLES idle-high cycles.
//   Exactly one frame is on the line at a time.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   req         per-requester level request, held until ack
//   data_in     requester i byte at [i*DATA_W +: DATA_W]
//   parity_en   insert even-parity bit, sampled at grant
//   ack         one-hot one-cycle pulse, coincident with first start-bit cycle
//   active_id   requester whose frame is (or was last) on the line
//   busy        high from first start-bit cycle through last gap cycle
//   serial_out  framed line, idle high
//   frame_done  one-cycle pulse in the last cycle of the stop bit
module serial_frame_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  data_in,
  input  logic                       parity_en,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       serial_out,
  output logic                       frame_done
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BIW = $clog2(DATA_W);

  localparam logic [3:0]     BIT_LAST = 4'(BIT_CYCLES - 1);
  localparam logic [3:0]     GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // stop-bit timer value one cycle before the last stop cycle
  localparam logic [3:0]     FD_TMR   = 4'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic              par_en_q;
  logic [BIW-1:0]    bit_idx;
  logic [3:0]        bit_tmr;
  logic [3:0]        gap_cnt;

  // ---------------------------------------------------------------------------
  // Round-robin winner: rotate req so rr_ptr sits at bit 0, take the lowest
  // set bit, then rotate the offset back.
  // ---------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDW:0]         off;
  logic [IDW:0]         win_sum;
  logic [IDW-1:0]       win;
  logic                 win_vld;
  logic [DATA_W-1:0]    win_data;

  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_rot[k]) off = (IDW+1)'(k);
    win_sum = {1'b0, rr_ptr} + off;
    if (win_sum >= (IDW+1)'(NUM_REQ)) win_sum = win_sum - (IDW+1)'(NUM_REQ);
    win     = win_sum[IDW-1:0];
    win_vld = |req;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (win == IDW'(k)) win_data = data_in[k*DATA_W +: DATA_W];
  end

  logic bit_last;
  logic gap_last;
  logic arb_ok;

  // Arbitration happens while idle and on the final edge of a frame, so
  // back-to-back frames carry no idle cycles beyond the gap.
  always_comb begin
    bit_last = (bit_tmr == BIT_LAST);
    gap_last = (gap_cnt == GAP_LAST);
    arb_ok   = (state == IDLE)
             | ((state == GAP) & gap_last)
             | ((state == STOP) & bit_last & (GAP_CYCLES == 0));
  end

  // ---------------------------------------------------------------------------
  // FSM. Outputs are registered and loaded with the value for the cycle that
  // the transition enters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      par_en_q   <= 1'b0;
      bit_idx    <= '0;
      bit_tmr    <= '0;
      gap_cnt    <= '0;
      ack        <= '0;
      active_id  <= '0;
      busy       <= 1'b0;
      serial_out <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      ack        <= '0;
      frame_done <= 1'b0;
      if (arb_ok) begin
        bit_tmr <= '0;
        gap_cnt <= '0;
        if (win_vld) begin
          state      <= START;
          shift      <= win_data;
          par_bit    <= ^win_data;
          par_en_q   <= parity_en;
          active_id  <= win;
          rr_ptr     <= (win == LAST_ID) ? '0 : win + 1'b1;
          ack        <= NUM_REQ'(1) << win;
          busy       <= 1'b1;
          serial_out <= 1'b0;
        end else begin
          state      <= IDLE;
          busy       <= 1'b0;
          serial_out <= 1'b1;
        end
      end else begin
        case (state)
          START: begin
            if (bit_last) begin
              state      <= DATA;
              bit_idx    <= '0;
              bit_tmr    <= '0;
              serial_out <= shift[0];
            end else begin
              bit_tmr <= bit_tmr + 1'b1;
            end
          end
          DATA: begin
            if (bit_last) begin
              bit_tmr <= '0;
              if (bit_idx == LAST_BIT) begin
                if (par_en_q) begin
                  state      <= PARITY;
                  serial_out <= par_bit;
                end else begin
                  state      <= STOP;
                  serial_out <= 1'b1;
                  frame_done <= (BIT_CYCLES == 1);
                end
              end else begin
                bit_idx    <= bit_idx + 1'b1;
                shift      <= {1'b0, shift[DATA_W-1:1]};
                serial_out <= shift[1];
              end
            end else begin
              bit_tmr <= bit_tmr + 1'b1;
            end
          end
          PARITY: begin
            if (bit_last) begin
              state      <= STOP;
              bit_tmr    <= '0;
              serial_out <= 1'b1;
              frame_done <= (BIT_CYCLES == 1);
            end else begin
              bit_tmr <= bit_tmr + 1'b1;
            end
          end
          STOP: begin
            // final stop edge with GAP_CYCLES == 0 is handled by arb_ok
            if (bit_last) begin
              state      <= GAP;
              gap_cnt    <= '0;
              bit_tmr    <= '0;
              serial_out <= 1'b1;
            end else begin
              bit_tmr    <= bit_tmr + 1'b1;
              frame_done <= (bit_tmr == FD_TMR);
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          default: begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
